// File: rtl/note_queue_synth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : note_queue_synth                                           |
// | Description : Memory-mapped note sequencer. Note words are queued in a   |
// |               DEPTH-entry FIFO and played in turn as square waves of     |
// |               programmable pitch, duration and volume. A 10-bit duty     |
// |               value drives the PWM serializer directly.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Optional feature macro: NOTE_QUEUE_SYNTH_FLUSH_EN                        |
// |   defined   : a write of 32'hFFFF_FFFF is a stop command (flush + IDLE)  |
// |   undefined : 32'hFFFF_FFFF is queued as an ordinary note                |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clock      in   1  system clock, all flops on posedge                   |
// |   reset      in   1  asynchronous, active-low                             |
// |   wr_en      in   1  one-cycle store strobe (already address-decoded)     |
// |   wr_data    in  32  note word {volume[3:0], duration[11:0], half[15:0]}  |
// |   status     out 32  {busy, full, empty, 24'b0, count[4:0]}               |
// |   duty_cycle out 10  PWM duty value, 512 = silence                        |
// |   overflow   out  1  one-cycle pulse when a write is dropped              |
// +--------------------------------------------------------------------------+
// | DEPTH must be a power of two and at least 2.                             |
// +--------------------------------------------------------------------------+
module note_queue_synth #(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] status,
  output logic [9:0]  duty_cycle,
  output logic        overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [9:0]       MIDSCALE = 10'd512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  // Note storage; read/write pointers wrap naturally at the power-of-two depth
  logic [31:0]      mem [DEPTH];

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      half_q, half_d;
  logic [11:0]      dur_q, dur_d;
  logic [3:0]       vol_q, vol_d;
  logic [15:0]      pitch_q, pitch_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             phase_q, phase_d;
  logic [9:0]       duty_q, duty_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      w_head;
  logic             w_flush;
  logic             w_pop;
  logic             w_push;
  logic [9:0]       w_swing;

  assign w_head = mem[rd_ptr_q];

`ifdef NOTE_QUEUE_SYNTH_FLUSH_EN
  assign w_flush = wr_en && (wr_data == 32'hFFFF_FFFF);
`else
  assign w_flush = 1'b0;
`endif

  // The head word is consumed on the edge that leaves LOAD. A flush wins
  // over that pop, so nothing is consumed on a flush cycle.
  assign w_pop  = (state_q == ST_LOAD) && !w_flush;
  // A full FIFO still accepts a write when the head is popped the same cycle
  assign w_push = wr_en && !w_flush && ((count_q != CNT_FULL) || w_pop);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    half_d   = half_q;
    dur_d    = dur_q;
    vol_d    = vol_q;
    pitch_d  = pitch_q;
    pre_d    = pre_q;
    phase_d  = phase_q;
    duty_d   = MIDSCALE;
    ovf_d    = wr_en && !w_flush && !w_push;
    w_swing  = {1'b0, vol_d, 5'b0};

    // FIFO bookkeeping
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        half_d  = w_head[15:0];
        dur_d   = w_head[27:16];
        vol_d   = w_head[31:28];
        pitch_d = '0;
        pre_d   = '0;
        phase_d = 1'b0;
        // A zero-duration note is skipped after its single LOAD cycle
        state_d = (w_head[27:16] == 12'd0) ? ST_IDLE : ST_PLAY;
      end

      ST_PLAY: begin
        if (pre_q == PRE_MAX) begin
          pre_d = '0;
          dur_d = dur_q - 12'd1;
          if (dur_q == 12'd1) begin
            state_d = (count_q != '0) ? ST_LOAD : ST_IDLE;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end

        // A rest (half period 0) holds the pitch counter and phase
        if (half_q != 16'd0) begin
          if (pitch_q == (half_q - 16'd1)) begin
            pitch_d = '0;
            phase_d = !phase_q;
          end else begin
            pitch_d = pitch_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_flush) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // Duty is computed from next-state values so the registered output lines
    // up with the state it belongs to. volume*32 <= 480 keeps it in 32..992.
    w_swing = {1'b0, vol_d, 5'b0};
    if ((state_d == ST_PLAY) && (half_d != 16'd0) && (vol_d != 4'd0)) begin
      duty_d = phase_d ? (MIDSCALE + w_swing) : (MIDSCALE - w_swing);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= '0;
      dur_q    <= '0;
      vol_q    <= '0;
      pitch_q  <= '0;
      pre_q    <= '0;
      phase_q  <= 1'b0;
      duty_q   <= MIDSCALE;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      half_q   <= half_d;
      dur_q    <= dur_d;
      vol_q    <= vol_d;
      pitch_q  <= pitch_d;
      pre_q    <= pre_d;
      phase_q  <= phase_d;
      duty_q   <= duty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Status is a pure decode of registered state; bits 28:5 are zero padding
  assign status = {(state_q != ST_IDLE),
                   (count_q == CNT_FULL),
                   (count_q == '0),
                   24'd0,
                   5'(count_q)};

  assign duty_cycle = duty_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_note_queue_synth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_note_queue_synth                                        |
// | Description : Self-checking bench for note_queue_synth (DEPTH 4,         |
// |               TICK_DIV 4). Vector table for the first tone, scoreboard   |
// |               of expected duty values for every busy cycle, and directed |
// |               sequences for overflow, skip, full+pop, reset and flush.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_note_queue_synth;

  localparam int DEPTH = 4;
  localparam int TICK  = 4;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] status;
  logic [9:0]  duty_cycle;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // Expected duty for each busy (LOAD/PLAY) cycle, oldest first
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic [31:0] st;
    logic [9:0]  duty;
    logic        ovf;
  } vec_t;

  note_queue_synth #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .status     (status),
    .duty_cycle (duty_cycle),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // One LOAD cycle at midscale, then duration*TICK PLAY cycles
  task automatic push_note(input logic [31:0] w);
    int hp, dur, vol, dv;
    hp  = int'(w[15:0]);
    dur = int'(w[27:16]);
    vol = int'(w[31:28]);
    exp_q.push_back(32'd512);
    for (int k = 0; k < dur * TICK; k++) begin
      if (hp == 0 || vol == 0) dv = 512;
      else if (((k / hp) % 2) == 1) dv = 512 + vol * 32;
      else dv = 512 - vol * 32;
      exp_q.push_back(32'(dv));
    end
  endtask

  task automatic write(input logic [31:0] w, input bit plays);
    wr_en   = 1'b1;
    wr_data = w;
    if (plays) push_note(w);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (status !== 32'h2000_0000 && n < max) begin
      step();
      n++;
    end
    check({name, "_idle"}, status, 32'h2000_0000);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic async_reset_pulse(input string name);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check({name, "_duty"}, 32'(duty_cycle), 32'd512);
    check({name, "_status"}, status, 32'h2000_0000);
    check({name, "_ovf"}, 32'(overflow), 32'd0);
    exp_q.delete();
    step();
    step();
    reset = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (mon_en) begin
      if (status[31]) begin
        if (exp_q.size() == 0) check("sb_unexpected_busy", status, 32'h2000_0000);
        else check("sb_duty", 32'(duty_cycle), exp_q.pop_front());
      end else begin
        check("idle_duty", 32'(duty_cycle), 32'd512);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1);
  end

  initial begin
    vec_t tv[15];

    tv[0]  = '{1'b1, 32'hF003_0002, 32'h0000_0001, 10'd512, 1'b0};
    tv[1]  = '{1'b0, 32'h0, 32'h8000_0001, 10'd512, 1'b0};
    for (int i = 2; i < 14; i++)
      tv[i] = '{1'b0, 32'h0, 32'hA000_0000,
                ((((i - 2) / 2) % 2) == 1) ? 10'd992 : 10'd32, 1'b0};
    tv[14] = '{1'b0, 32'h0, 32'h2000_0000, 10'd512, 1'b0};

    // Reset values
    repeat (3) step();
    check("rst_duty", 32'(duty_cycle), 32'd512);
    check("rst_status", status, 32'h2000_0000);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    step();
    mon_en = 1'b1;

    // Reset and tone: table-driven, one record per cycle
    for (int i = 0; i < 15; i++) begin
      wr_en   = tv[i].wr;
      wr_data = tv[i].data;
      if (tv[i].wr) push_note(tv[i].data);
      step();
      wr_en = 1'b0;
      check($sformatf("t1_status[%0d]", i), status, tv[i].st);
      check($sformatf("t1_duty[%0d]", i), 32'(duty_cycle), 32'(tv[i].duty));
      check($sformatf("t1_ovf[%0d]", i), 32'(overflow), 32'(tv[i].ovf));
    end
    wait_idle("t1", 5);

    // Overflow: five writes while a note plays, fifth dropped
    write(32'h8004_0003, 1'b1);
    step();
    step();
    for (int i = 1; i <= 5; i++) begin
      write(32'h8010_0005, i <= 4);
      check($sformatf("t2_status[%0d]", i), status,
            (i >= 4) ? 32'hC000_0004 : (32'h8000_0000 | 32'(i)));
      check($sformatf("t2_ovf[%0d]", i), 32'(overflow), (i == 5) ? 32'd1 : 32'd0);
    end
    step();
    check("t2_ovf_clear", 32'(overflow), 32'd0);
    check("t2_still_full", status, 32'hC000_0004);
    wait_idle("t2", 600);

    // Rest, skipped zero-duration note, then quiet tone
    write(32'h8002_0000, 1'b1);
    write(32'h8000_0003, 1'b1);
    write(32'h4001_0001, 1'b1);
    wait_idle("t3", 100);

    // Full FIFO with a write on the LOAD cycle
    write(32'h8004_0001, 1'b1);
    step();
    step();
    for (int i = 0; i < 4; i++) write(32'h8001_0002, 1'b1);
    check("t4_full", status, 32'hC000_0004);
    begin
      int n;
      n = 0;
      while (!(status[31] && status[30] && duty_cycle == 10'd512) && n < 100) begin
        step();
        n++;
      end
      check("t4_find_load", 32'(n < 100), 32'd1);
    end
    write(32'h8001_0003, 1'b1);
    check("t4_count_stays", status, 32'hC000_0004);
    check("t4_no_ovf", 32'(overflow), 32'd0);
    wait_idle("t4", 400);

    // Reset mid-note with residual notes queued
    write(32'h8004_0003, 1'b1);
    write(32'h8001_0001, 1'b1);
    step();
    step();
    check("t5_playing", 32'(status[31]), 32'd1);
    async_reset_pulse("t5_rst");
    repeat (20) step();
    check("t5_no_residual", status, 32'h2000_0000);

    // All-ones word: stop command or ordinary note depending on build
    write(32'h8004_0003, 1'b1);
    step();
    step();
    for (int i = 0; i < 3; i++) write(32'h8001_0001, 1'b1);
    check("t6_queued", status, 32'h8000_0003);
`ifdef NOTE_QUEUE_SYNTH_FLUSH_EN
    write(32'hFFFF_FFFF, 1'b0);
    check("t6_flush_status", status, 32'h2000_0000);
    check("t6_flush_duty", 32'(duty_cycle), 32'd512);
    check("t6_flush_ovf", 32'(overflow), 32'd0);
    exp_q.delete();
    repeat (10) step();
    check("t6_flush_idle", status, 32'h2000_0000);
`else
    write(32'hFFFF_FFFF, 1'b0);
    check("t6_enqueue_ffff", status, 32'hC000_0004);
    check("t6_enqueue_ovf", 32'(overflow), 32'd0);
    async_reset_pulse("t6_rst");
    repeat (5) step();
    check("t6_idle_after_rst", status, 32'h2000_0000);
`endif

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
